// File: rtl/read_engine.sv
// read_engine: fetches LEN words from a valid/ready source into a circular
// FIFO while read_data is held. It then reports completion, or a watchdog
// fault, as a one-cycle pulse and waits in HOLD until read_data drops.
module read_engine #(
  parameter int DATA_W  = 8,
  parameter int LEN     = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_data,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     data_read_complete,
  output logic                     error,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {IDLE, FETCH, DONE, FAULT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     wcnt;
  logic [WW-1:0]     wdog;
  logic [PW-1:0]     wptr, rptr;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] mem [DEPTH];

  logic full, empty, accept, pop, last, expire;

  // full is taken from the registered level, so a same-cycle pop never
  // opens in_ready; the source only sees room that already exists.
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = (state == FETCH) && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = out_ready && !empty;
  assign last     = accept && (wcnt == CW'(LEN - 1));
  // An accept in the expiry cycle restarts the watchdog rather than faulting.
  assign expire   = !accept && (wdog == WW'(TIMEOUT - 1));

  // Next-state logic; dropping read_data during FETCH takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read_data) state_nxt = FETCH;
      FETCH: begin
        if (!read_data)  state_nxt = IDLE;
        else if (last)   state_nxt = DONE;
        else if (expire) state_nxt = FAULT;
      end
      DONE:    state_nxt = HOLD;
      FAULT:   state_nxt = HOLD;
      HOLD:    if (!read_data) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Word counter and watchdog; both sit at zero outside FETCH so every start is fresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= '0;
      wdog <= '0;
    end else if (state != FETCH) begin
      wcnt <= '0;
      wdog <= '0;
    end else if (accept) begin
      wcnt <= wcnt + CW'(1);
      wdog <= '0;
    end else begin
      wdog <= wdog + WW'(1);
    end
  end

  // FIFO pointers and occupancy; only reset flushes the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (accept) wptr <= wptr + PW'(1);
      if (pop)    rptr <= rptr + PW'(1);
      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because out_data is masked when empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= in_data;
  end

  assign out_valid          = !empty;
  assign out_data           = empty ? '0 : mem[rptr];
  assign fifo_level         = level;
  assign data_read_complete = (state == DONE);
  assign error              = (state == FAULT);
  assign busy               = (state == FETCH);

endmodule

// File: tb/tb_read_engine.sv
// Bench for read_engine: scenario tasks with their own inline checks.
// A transaction-level reference model (queue FIFO, accept/stall counters)
// is compared against every output on every falling edge.
module tb_read_engine;
  localparam int DATA_W  = 8;
  localparam int LEN     = 10;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 5;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0, reset = 1'b0;
  logic              read_data = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid, data_read_complete, error, busy;
  logic [DATA_W-1:0] out_data;
  logic [LW-1:0]     fifo_level;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  int cyc = 0, n_done = 0, n_err = 0, done_cyc = 0, err_cyc = 0;

  read_engine #(.DATA_W(DATA_W), .LEN(LEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .read_data(read_data), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .data_read_complete(data_read_complete), .error(error), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is in progress, a pulse is showing,
  // or the engine waits for read_data to fall.
  logic [DATA_W-1:0] m_q[$];
  bit m_fetch = 0, m_hold = 0, m_done = 0, m_err = 0;
  int m_cnt = 0, m_stall = 0, m_nacc = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fetch = 0; m_hold = 0; m_done = 0; m_err = 0;
      m_cnt = 0; m_stall = 0; m_q.delete();
    end else begin
      bit acc, pp, pulse;
      acc   = m_fetch && in_valid && (m_q.size() < DEPTH);
      pp    = out_ready && (m_q.size() != 0);
      pulse = m_done || m_err;
      m_done = 0; m_err = 0;
      if (pp) void'(m_q.pop_front());
      if (acc) begin m_q.push_back(in_data); m_nacc++; end
      if (m_fetch) begin
        if (!read_data) m_fetch = 0;
        else if (acc && m_cnt + 1 == LEN) begin m_fetch = 0; m_hold = 1; m_done = 1; end
        else if (!acc && m_stall == TIMEOUT - 1) begin m_fetch = 0; m_hold = 1; m_err = 1; end
        else if (acc) begin m_cnt++; m_stall = 0; end
        else m_stall++;
      end else if (!pulse) begin
        if (m_hold) begin
          if (!read_data) m_hold = 0;
        end else if (read_data) begin
          m_fetch = 1; m_cnt = 0; m_stall = 0;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int sz;
    logic [DATA_W-1:0] e_data;
    if (chk_en) begin
      sz = m_q.size();
      e_data = (sz != 0) ? m_q[0] : '0;
      vectors++;
      if (in_ready !== (m_fetch && sz < DEPTH) || out_valid !== (sz != 0) ||
          out_data !== e_data || data_read_complete !== m_done || error !== m_err ||
          busy !== m_fetch || fifo_level !== LW'(sz)) begin
        miscompares++;
        $display("FAIL model_cycle %0d: rdy/vld/data/cmp/err/busy/lvl got %b/%b/%h/%b/%b/%b/%0d want %b/%b/%h/%b/%b/%b/%0d",
                 cyc, in_ready, out_valid, out_data, data_read_complete, error, busy, fifo_level,
                 m_fetch && sz < DEPTH, sz != 0, e_data, m_done, m_err, m_fetch, sz);
      end
    end
  end

  // Pulse counters and cycle index (sampled before the edge updates state).
  always @(posedge clk) begin
    if (data_read_complete === 1'b1) begin n_done++; done_cyc = cyc; end
    if (error === 1'b1) begin n_err++; err_cyc = cyc; end
    cyc++;
  end

  task automatic drain;
    read_data = 0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (m_q.size() == 0 && !m_fetch && !m_hold && !m_done && !m_err) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, out_data, data_read_complete, error, busy, fifo_level} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want all zero",
               {in_ready, out_valid, out_data, data_read_complete, error, busy, fifo_level});
    end
    #2 reset = 1;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    int n0, d0, start_cyc, popi;
    logic [DATA_W-1:0] exp_d;
    n0 = m_nacc; d0 = n_done; popi = 0;
    @(negedge clk);
    read_data = 1; in_valid = 1; out_ready = 1; in_data = 8'h10;
    @(negedge clk);
    start_cyc = cyc;
    for (int k = 0; k < 60; k++) begin
      if (out_valid && out_ready) begin
        exp_d = DATA_W'(16 + popi);
        vectors++;
        if (out_data !== exp_d) begin
          miscompares++;
          $display("FAIL nominal_data[%0d]: got %h want %h", popi, out_data, exp_d);
        end
        popi++;
      end
      in_data = DATA_W'(16 + m_nacc - n0);
      if (m_nacc - n0 >= LEN) in_valid = 0;
      if (popi == LEN && n_done != d0) break;
      @(negedge clk);
    end
    read_data = 0; in_valid = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (n_done - d0 != 1) begin
      miscompares++; $display("FAIL nominal_pulses: got %0d want 1", n_done - d0);
    end
    // The pulse occupies the (LEN+1)th cycle counting the start cycle.
    vectors++;
    if (done_cyc - start_cyc != LEN) begin
      miscompares++; $display("FAIL nominal_latency: got %0d want %0d", done_cyc - start_cyc, LEN);
    end
    vectors++;
    if (popi != LEN || fifo_level !== '0) begin
      miscompares++; $display("FAIL nominal_drain: popped %0d level %0d want %0d and 0", popi, fifo_level, LEN);
    end
  endtask

  task automatic test_backpressure;
    int n0, d0;
    drain();
    n0 = m_nacc; d0 = n_done;
    read_data = 1; in_valid = 1; out_ready = 0; in_data = DATA_W'($urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_data = DATA_W'($urandom);
      if (m_nacc - n0 == DEPTH) break;
    end
    vectors++;
    if (in_ready !== 1'b0 || fifo_level !== LW'(DEPTH) || n_done != d0) begin
      miscompares++;
      $display("FAIL bp_full: rdy %b lvl %0d pulses %0d want 0 %0d 0", in_ready, fifo_level, DEPTH, n_done - d0);
    end
    out_ready = 1;
    @(negedge clk);
    in_data = DATA_W'($urandom);
    @(negedge clk);
    out_ready = 0; in_data = DATA_W'($urandom);
    for (int k = 0; k < 10; k++) begin
      if (n_done != d0) break;
      @(negedge clk);
    end
    vectors++;
    if (n_done - d0 != 1 || m_nacc - n0 != LEN) begin
      miscompares++;
      $display("FAIL bp_complete: pulses %0d accepts %0d want 1 %0d", n_done - d0, m_nacc - n0, LEN);
    end
    vectors++;
    if (fifo_level !== LW'(DEPTH)) begin
      miscompares++; $display("FAIL bp_level_end: got %0d want %0d", fifo_level, DEPTH);
    end
    drain();
  endtask

  task automatic test_watchdog;
    int n0, e0, acc_cyc;
    drain();
    n0 = m_nacc; e0 = n_err;
    read_data = 1; in_valid = 1; out_ready = 1; in_data = DATA_W'($urandom);
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (m_nacc != n0) break; end
    in_valid = 0; acc_cyc = cyc;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (n_err != e0) break; end
    vectors++;
    if (n_err - e0 != 1 || err_cyc - acc_cyc != TIMEOUT) begin
      miscompares++;
      $display("FAIL wd_error: pulses %0d delay %0d want 1 %0d", n_err - e0, err_cyc - acc_cyc, TIMEOUT);
    end
    in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL wd_hold: rdy %b busy %b want 0 0", in_ready, busy);
      end
    end
    vectors++;
    if (n_err - e0 != 1) begin
      miscompares++; $display("FAIL wd_single: got %0d want 1", n_err - e0);
    end
    read_data = 0; in_valid = 0;
    repeat (2) @(negedge clk);
    // A word arriving on the expiry edge wins over the fault.
    n0 = m_nacc; e0 = n_err;
    read_data = 1; in_valid = 1;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (m_nacc != n0) break; end
    in_valid = 0; acc_cyc = cyc;
    for (int k = 0; k < 20; k++) begin if (cyc == acc_cyc + TIMEOUT - 1) break; @(negedge clk); end
    in_valid = 1; in_data = DATA_W'($urandom);
    @(negedge clk);
    in_valid = 0;
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1 || m_nacc - n0 != 2) begin
      miscompares++;
      $display("FAIL wd_late_word: err %b busy %b accepts %0d want 0 1 2", error, busy, m_nacc - n0);
    end
    repeat (2) @(negedge clk);
    read_data = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (n_err != e0) begin
      miscompares++; $display("FAIL wd_no_fault: got %0d want 0", n_err - e0);
    end
  endtask

  task automatic test_abort;
    int n0, n1, d0, e0;
    drain();
    n0 = m_nacc; d0 = n_done; e0 = n_err;
    read_data = 1; in_valid = 1; out_ready = 0; in_data = 8'hA0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_data = DATA_W'(8'hA0 + m_nacc - n0);
      if (m_nacc - n0 == 2) break;
    end
    read_data = 0; in_valid = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || fifo_level !== LW'(2) || out_data !== 8'hA0 || n_done != d0 || n_err != e0) begin
      miscompares++;
      $display("FAIL abort_state: busy %b lvl %0d head %h pulses %0d/%0d want 0 2 a0 0/0",
               busy, fifo_level, out_data, n_done - d0, n_err - e0);
    end
    n1 = m_nacc;
    read_data = 1; in_valid = 1; out_ready = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_data = DATA_W'($urandom);
      if (n_done != d0) break;
    end
    vectors++;
    if (m_nacc - n1 != LEN || n_done - d0 != 1) begin
      miscompares++;
      $display("FAIL abort_refetch: accepts %0d pulses %0d want %0d 1", m_nacc - n1, n_done - d0, LEN);
    end
    drain();
  endtask

  task automatic test_hold;
    int d0;
    drain();
    d0 = n_done;
    read_data = 1; in_valid = 1; out_ready = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      in_data = DATA_W'($urandom);
      if (data_read_complete === 1'b1) break;
    end
    repeat (10) begin
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL hold_quiet: rdy %b busy %b want 0 0", in_ready, busy);
      end
      @(negedge clk);
    end
    vectors++;
    if (n_done - d0 != 1) begin
      miscompares++; $display("FAIL hold_pulses: got %0d want 1", n_done - d0);
    end
    read_data = 0;
    @(negedge clk);
    read_data = 1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL hold_restart: busy got %b want 1", busy);
    end
    drain();
  endtask

  task automatic test_random;
    int d0, e0;
    bit aborted, ended;
    for (int t = 0; t < 8; t++) begin
      d0 = n_done; e0 = n_err; aborted = 0; ended = 0;
      read_data = 1;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        if (n_done != d0 || n_err != e0) begin ended = 1; break; end
        if (m_fetch && $urandom_range(0, 59) == 0) begin aborted = 1; ended = 1; break; end
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 1) == 1);
        in_data   = DATA_W'($urandom);
      end
      read_data = 0; in_valid = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if (!ended || (!aborted && (n_done - d0) + (n_err - e0) != 1)) begin
        miscompares++;
        $display("FAIL random_txn %0d: ended %b done %0d err %0d want one pulse", t, ended, n_done - d0, n_err - e0);
      end
    end
    drain();
  endtask

  task automatic test_async_reset;
    int n0, d0, e0;
    drain();
    n0 = m_nacc; d0 = n_done; e0 = n_err;
    read_data = 1; in_valid = 1; out_ready = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_data = DATA_W'($urandom);
      if (m_nacc - n0 == 3) break;
    end
    #2 reset = 0;
    #1;
    vectors++;
    if ({in_ready, out_valid, out_data, data_read_complete, error, busy, fifo_level} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want all zero",
               {in_ready, out_valid, out_data, data_read_complete, error, busy, fifo_level});
    end
    read_data = 0; in_valid = 0;
    @(negedge clk);
    #2 reset = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (fifo_level !== '0 || busy !== 1'b0 || n_done != d0 || n_err != e0) begin
      miscompares++;
      $display("FAIL async_release: lvl %0d busy %b pulses %0d/%0d want 0 0 0/0",
               fifo_level, busy, n_done - d0, n_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_watchdog();
    test_abort();
    test_hold();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/read_engine.md
# read_engine

Fetch stage feeding the transaction controller's READ phase. While the controller holds `read_data` high, the engine pulls exactly LEN words from an upstream valid/ready stream into an internal FIFO. It then returns a one-cycle `data_read_complete` pulse, or a one-cycle `error` pulse if the source stalls past a watchdog limit. The FIFO read side feeds the processing stage.

## Interface
- DATA_W, 8, data word width
- LEN, 4, words fetched per transaction (1..255)
- DEPTH, 8, FIFO entries (power of two, ≥ 2)
- TIMEOUT, 255, max consecutive FETCH cycles without an accepted word (1..65535)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- read_data  in  1  level request from controller; high for the whole READ phase
- in_valid  in  1  upstream word valid
- in_data  in  DATA_W  upstream word
- in_ready  out  1  engine accepts word this cycle
- out_valid  out  1  FIFO non-empty
- out_data  out  DATA_W  FIFO head word
- out_ready  in  1  downstream pops head when out_valid
- data_read_complete  out  1  one-cycle pulse, LEN words accepted
- error  out  1  one-cycle pulse, watchdog expired
- busy  out  1  high in FETCH
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- States: IDLE, FETCH, DONE, FAULT, HOLD.
- IDLE: in_ready=0. `read_data`=1 → FETCH; word counter and watchdog cleared.
- FETCH: in_ready = !full, where full is evaluated before this cycle's pop. Word accepted when in_valid & in_ready; it is pushed and the word counter increments.
  - The LEN-th word is accepted → DONE.
  - The watchdog counts cycles with no accepted word and clears on every accept. Watchdog = TIMEOUT−1 with no accept this cycle → FAULT.
  - An accept in the same cycle as watchdog expiry wins; that cycle is not a fault.
  - `read_data`=0 → IDLE (abort). No pulse. Words already pushed stay in the FIFO.
- DONE: one cycle. data_read_complete=1. Next state is HOLD.
- FAULT: one cycle. error=1. Next state is HOLD.
- HOLD: in_ready=0. Waits for `read_data`=0, then → IDLE. This prevents re-triggering while the controller is still in READ.
- FIFO: circular buffer of DEPTH entries.
  - Push and pop in the same cycle are both honoured; level is unchanged.
  - Pop when empty is ignored.
  - No push when full, because in_ready is low.
  - The FIFO is flushed only by reset, never by start, abort or fault.
- Widths: word counter is $clog2(LEN+1) bits. Watchdog is $clog2(TIMEOUT+1) bits. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (reset=0), asynchronous. State goes to IDLE; all counters and pointers go to 0. Outputs: in_ready=0, out_valid=0, out_data=0, data_read_complete=0, error=0, busy=0, fifo_level=0. FIFO storage contents are don't-care.
- Reset asserted mid-FETCH aborts immediately. No pulse is produced after reset is released.
- read_data sampled high at edge N → state is FETCH from N; in_ready can be high in cycle N+1.
- in_ready is combinational from state and full. It does not depend on in_valid.
- Last word accepted at edge M → data_read_complete high during cycle M+1 (registered), exactly one cycle.
- Fetch latency is LEN+1 cycles minimum with in_valid held high and no backpressure.
- Pushed word: out_valid is high the cycle after the push edge (no write-through to the read side).
- A word pushed at edge M is visible on out_data from cycle M+1 if the FIFO was empty.
- error is high for exactly one cycle, registered, the cycle after the expiry edge.
- busy = (state == FETCH), registered with the state.

## Test plan
- Nominal fetch: LEN=4, read_data=1, in_valid=1, in_data=0x10..0x13, out_ready=1.
  - data_read_complete pulses exactly once, 5 cycles after start.
  - out_data yields 0x10, 0x11, 0x12, 0x13 in order; fifo_level returns to 0.
- Backpressure and full: DEPTH=8, LEN=10, out_ready=0.
  - in_ready drops after 8 accepts; fifo_level=8; no data_read_complete.
  - Raise out_ready for 2 cycles → the remaining 2 words are accepted, then data_read_complete pulses.
  - Same-cycle push and pop at level 8 with level staying at 8 is never seen, since in_ready is low while full.
- Watchdog: TIMEOUT=5. Accept 1 word, then hold in_valid=0.
  - error pulses exactly one cycle, 5 cycles after that accept; state goes to HOLD; in_ready=0 until read_data falls.
  - Repeat with a word arriving in the expiry cycle → no error.
- Abort: drop read_data after 2 of 4 words.
  - Engine returns to IDLE; no data_read_complete, no error; fifo_level=2, with the words retained.
  - Re-raise read_data → a fresh count of 4 words is fetched.
- HOLD: keep read_data=1 for 10 cycles after data_read_complete.
  - Exactly one pulse; in_ready=0 throughout; a new fetch starts only after read_data goes 0 then 1.
- Async reset mid-FETCH: pull reset low between clock edges after 3 words.
  - All outputs are 0 immediately; after release, fifo_level=0, state is IDLE, and no pulse is emitted.
